// File: rtl/main_ram_pkg.sv
// Shared constants for the main RAM bus and its arbiter.
//   MAIN_RAM_ADDR_WIDTH / DATA_WIDTH / NIBBLES : RAM bus geometry
//   PORT_CPU / PORT_FETCH0 / PORT_FETCH1       : requester indices
//   next_port()                                : (k+1) mod 3
package main_ram_pkg;
  localparam int MAIN_RAM_ADDR_WIDTH = 15;
  localparam int MAIN_RAM_DATA_WIDTH = 32;
  localparam int MAIN_RAM_NIBBLES    = 8;

  localparam logic [1:0] PORT_CPU    = 2'd0;
  localparam logic [1:0] PORT_FETCH0 = 2'd1;
  localparam logic [1:0] PORT_FETCH1 = 2'd2;

  function automatic logic [1:0] next_port(input logic [1:0] k);
    return (k == PORT_FETCH1) ? PORT_CPU : k + 2'd1;
  endfunction
endpackage

// File: rtl/main_ram_arbiter_rr_pick3.sv
// rr_pick3: combinational 3-way rotate-priority picker.
//   req_i   [2:0] pending requests
//   start_i [1:0] first index searched (3 is treated as 0)
//   grant_o [2:0] onehot winner, zero when nothing pending
//   any_o         some request granted
module rr_pick3 (
  input  logic [2:0] req_i,
  input  logic [1:0] start_i,
  output logic [2:0] grant_o,
  output logic       any_o
);
  always_comb begin
    logic [1:0] s;
    logic [1:0] idx;
    logic       found;
    grant_o = '0;
    found   = 1'b0;
    s       = (start_i == 2'd3) ? 2'd0 : start_i;
    idx     = s;
    for (int i = 0; i < 3; i++) begin
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
    any_o = found;
  end
endmodule

// File: rtl/main_ram_arbiter.sv
// main_ram_arbiter: shares the single-port main RAM between the host CPU
// (port 0) and two display/renderer fetch ports (1, 2). One grant per clock,
// round-robin; read data comes back one cycle after the ack and is flagged
// on the issuing port's rddata_valid.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   pN_req/addr/wrdata/
//   pN_wrnibblesel/write           requester N access, held until pN_ack
//   pN_ack                         combinational accept
//   pN_rddata, pN_rddata_valid     read return (data mirrors bus_rddata)
//   bus_*                          RAM bus
//
// Build option: define MAIN_RAM_ARB_CPU_PRIORITY_EN to let port 0 win
// whenever it requests, limited to CPU_MAX_CONSEC grants in a row while a
// fetch port waits.
module main_ram_arbiter
  import main_ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = MAIN_RAM_ADDR_WIDTH,
  parameter int CPU_MAX_CONSEC = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           p0_req,
  input  logic [ADDR_WIDTH-1:0]          p0_addr,
  input  logic [MAIN_RAM_DATA_WIDTH-1:0] p0_wrdata,
  input  logic [MAIN_RAM_NIBBLES-1:0]    p0_wrnibblesel,
  input  logic                           p0_write,
  output logic                           p0_ack,
  output logic [MAIN_RAM_DATA_WIDTH-1:0] p0_rddata,
  output logic                           p0_rddata_valid,
  input  logic                           p1_req,
  input  logic [ADDR_WIDTH-1:0]          p1_addr,
  input  logic [MAIN_RAM_DATA_WIDTH-1:0] p1_wrdata,
  input  logic [MAIN_RAM_NIBBLES-1:0]    p1_wrnibblesel,
  input  logic                           p1_write,
  output logic                           p1_ack,
  output logic [MAIN_RAM_DATA_WIDTH-1:0] p1_rddata,
  output logic                           p1_rddata_valid,
  input  logic                           p2_req,
  input  logic [ADDR_WIDTH-1:0]          p2_addr,
  input  logic [MAIN_RAM_DATA_WIDTH-1:0] p2_wrdata,
  input  logic [MAIN_RAM_NIBBLES-1:0]    p2_wrnibblesel,
  input  logic                           p2_write,
  output logic                           p2_ack,
  output logic [MAIN_RAM_DATA_WIDTH-1:0] p2_rddata,
  output logic                           p2_rddata_valid,
  output logic [ADDR_WIDTH-1:0]          bus_addr,
  output logic [MAIN_RAM_DATA_WIDTH-1:0] bus_wrdata,
  output logic [MAIN_RAM_NIBBLES-1:0]    bus_wrnibblesel,
  output logic                           bus_write,
  input  logic [MAIN_RAM_DATA_WIDTH-1:0] bus_rddata
);
  logic [2:0] req;
  logic [1:0] rr_next_q, rr_next_d;
  logic       rd_pending_q, rd_pending_d;
  logic [1:0] rd_port_q, rd_port_d;
  logic [2:0] pick_req, pick_gnt, gnt;
  logic       pick_any;
  logic [1:0] win;

  assign req = {p2_req, p1_req, p0_req};

  rr_pick3 u_pick (
    .req_i   (pick_req),
    .start_i (rr_next_q),
    .grant_o (pick_gnt),
    .any_o   (pick_any)
  );

`ifdef MAIN_RAM_ARB_CPU_PRIORITY_EN
  localparam int CW = $clog2(CPU_MAX_CONSEC + 1);
  logic [CW-1:0] consec_q, consec_d;
  logic          others, cpu_masked;

  assign others     = req[PORT_FETCH0] | req[PORT_FETCH1];
  // Masking only matters if a fetch port is actually there to take the slot.
  assign cpu_masked = (consec_q == CW'(CPU_MAX_CONSEC)) && others;
  // The picker only ever arbitrates between the fetch ports.
  assign pick_req   = {req[2:1], 1'b0};

  always_comb begin
    gnt = '0;
    if (!rst) begin
      if (req[PORT_CPU] && !cpu_masked) gnt = 3'b001;
      else                              gnt = pick_gnt;
    end
  end

  assign consec_d = (gnt[PORT_CPU] && others) ? consec_q + CW'(1) : '0;

  always_comb begin
    rr_next_d = rr_next_q;
    if (gnt[PORT_FETCH0] || gnt[PORT_FETCH1]) rr_next_d = next_port(win);
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^CPU_MAX_CONSEC;
  assign pick_req   = req;
  assign gnt        = rst ? 3'b000 : pick_gnt;

  always_comb begin
    rr_next_d = rr_next_q;
    if (|gnt) rr_next_d = next_port(win);
  end
`endif

  assign win = gnt[PORT_FETCH0] ? PORT_FETCH0 :
               gnt[PORT_FETCH1] ? PORT_FETCH1 : PORT_CPU;

  // Winner's fields onto the bus; all-zero when idle or in reset.
  always_comb begin
    bus_addr        = '0;
    bus_wrdata      = '0;
    bus_wrnibblesel = '0;
    bus_write       = 1'b0;
    unique case (1'b1)
      gnt[0]: begin
        bus_addr = p0_addr; bus_wrdata = p0_wrdata;
        bus_wrnibblesel = p0_wrnibblesel; bus_write = p0_write;
      end
      gnt[1]: begin
        bus_addr = p1_addr; bus_wrdata = p1_wrdata;
        bus_wrnibblesel = p1_wrnibblesel; bus_write = p1_write;
      end
      gnt[2]: begin
        bus_addr = p2_addr; bus_wrdata = p2_wrdata;
        bus_wrnibblesel = p2_wrnibblesel; bus_write = p2_write;
      end
      default: ;
    endcase
  end

  assign rd_pending_d = (|gnt) && !bus_write;
  assign rd_port_d    = win;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_next_q    <= PORT_CPU;
      rd_pending_q <= 1'b0;
      rd_port_q    <= PORT_CPU;
`ifdef MAIN_RAM_ARB_CPU_PRIORITY_EN
      consec_q     <= '0;
`endif
    end else begin
      rr_next_q    <= rr_next_d;
      rd_pending_q <= rd_pending_d;
      rd_port_q    <= rd_port_d;
`ifdef MAIN_RAM_ARB_CPU_PRIORITY_EN
      consec_q     <= consec_d;
`endif
    end
  end

  assign {p2_ack, p1_ack, p0_ack} = gnt;

  assign p0_rddata_valid = !rst && rd_pending_q && (rd_port_q == PORT_CPU);
  assign p1_rddata_valid = !rst && rd_pending_q && (rd_port_q == PORT_FETCH0);
  assign p2_rddata_valid = !rst && rd_pending_q && (rd_port_q == PORT_FETCH1);

  assign p0_rddata = bus_rddata;
  assign p1_rddata = bus_rddata;
  assign p2_rddata = bus_rddata;
endmodule

// File: doc/main_ram_arbiter.md
Name: main_ram_arbiter

Overview:
- Shares the single-port 128 KB main RAM (32-bit words, 15-bit word address, nibble write mask, 1-cycle read latency) between three requesters: port 0 = host CPU interface, ports 1/2 = display/renderer fetch.
- Sits directly in front of main_ram and drives its bus inputs.
- Grants at most one access per clock, using round-robin among pending ports.
- Routes each read result back to the requester that issued it.

Parameters:
- ADDR_WIDTH, 15, word address width; must match the RAM bus.
- CPU_MAX_CONSEC, 4, max back-to-back port-0 grants while another port waits (used only with CPU_PRIORITY_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pN_req  in  1  request; N = 0,1,2; held until pN_ack
- pN_addr  in  ADDR_WIDTH  word address
- pN_wrdata  in  32  write data
- pN_wrnibblesel  in  8  nibble write enables
- pN_write  in  1  1 = write, 0 = read
- pN_ack  out  1  request accepted this cycle (combinational)
- pN_rddata  out  32  read data, qualified by pN_rddata_valid
- pN_rddata_valid  out  1  one-cycle pulse, cycle after a read ack
- bus_addr  out  ADDR_WIDTH  to RAM
- bus_wrdata  out  32  to RAM
- bus_wrnibblesel  out  8  to RAM
- bus_write  out  1  to RAM
- bus_rddata  in  32  from RAM

Behaviour:
- Grant (combinational, same cycle):
  - Search pending reqs starting at rr_next (registered, 0..2) in order rr_next, rr_next+1, rr_next+2, mod 3.
  - The first hit is the winner; exactly one pN_ack is asserted, for the winner only.
  - Bus outputs carry the winner's addr, wrdata, wrnibblesel and write.
- Idle (no req): bus_addr = 0, bus_wrdata = 0, bus_wrnibblesel = 0, bus_write = 0, all acks 0.
- Pointer update: on a grant to port k, rr_next <= (k+1) mod 3. With no grant, rr_next holds.
- Read return:
  - On a read ack, register rd_pending = 1 and rd_port = k.
  - Next cycle: p{rd_port}_rddata_valid = 1, and p{rd_port}_rddata = bus_rddata.
  - Write acks set rd_pending = 0, so no valid pulse follows a write.
- Read-data buses: all pN_rddata continuously mirror bus_rddata. Only rddata_valid is port-specific.
- Throughput: one access per cycle. Back-to-back reads from different ports pipeline with no bubble.
- Requester rules:
  - A requester may keep req high after ack to issue its next access.
  - Inputs are sampled only in the ack cycle.
  - req dropped before ack is legal and cancels the request.
- Write nibble mask passes through unmodified. wrnibblesel = 0 with write = 1 is a legal no-op write that still consumes a grant slot.
- While rst = 1:
  - all acks, bus_write and all rddata_valid are 0; bus outputs are 0.
  - rr_next <= 0, rd_pending <= 0, consec count <= 0.
  - A read acked in the cycle rst rises produces no valid pulse.
- Simultaneous req on all three ports with rr_next = 0: grant order 0,1,2,0,...
- Fairness: each continuously requesting port is granted within 3 cycles.

Optional Feature:
- Macro: MAIN_RAM_ARB_CPU_PRIORITY_EN.
- Enabled:
  - Port 0 wins whenever p0_req = 1, regardless of rr_next, except as limited below.
  - A counter cpu_consec increments on each port-0 grant made while p1_req or p2_req is pending. It clears on any non-port-0 grant or on a cycle with no other pending port.
  - When cpu_consec == CPU_MAX_CONSEC, port 0 is masked for one arbitration. The round-robin search among ports 1/2 wins, then the counter clears.
  - rr_next updates only on port 1/2 grants.
- Disabled: pure round-robin as above; cpu_consec logic absent.

Decomposition:
- Shared package/include (main_ram_pkg): MAIN_RAM_ADDR_WIDTH = 15, MAIN_RAM_DATA_WIDTH = 32, MAIN_RAM_NIBBLES = 8, port indices PORT_CPU = 0, PORT_FETCH0 = 1, PORT_FETCH1 = 2.
- One sub-module: rr_pick3, a combinational 3-way rotate-priority picker (req[2:0], start[1:0] -> onehot grant[2:0], any).
- Pointer, counter and read-return pipeline stay in main_ram_arbiter.

Test Plan:
- Single read: p1 reads addr 0x1000 (RAM holds 0x12345678) -> p1_ack in cycle T, p1_rddata_valid = 1 with rddata 0x12345678 in T+1, no other valid.
- All three reqs held continuously, rr_next = 0, reads -> acks 0,1,2,0,1,2 on consecutive cycles; each valid pulse lands on the matching port one cycle later.
- p0 write 0xAABBCCDD with nibblesel 0x0F to addr 5 (holding 0x00000005), then p2 reads addr 5 -> p2 gets 0x0000CCDD, and no valid pulse for p0.
- rst asserted in the same cycle as a p2 read ack -> no p2_rddata_valid the next cycle; after release, p0, p1 and p2 all requesting gives the first grant to port 0.
- With MAIN_RAM_ARB_CPU_PRIORITY_EN, CPU_MAX_CONSEC = 4, p0 and p1 requesting continuously -> grant pattern 0,0,0,0,1 repeating.
- Without the macro, same stimulus -> grants alternate 0,1,0,1.
